// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Index width for n items; never below one bit so single-entry counters still exist.
    function automatic int grant_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] pick,
    output logic               any_valid
);

    logic [GRANT_W-1:0] idx_s;

    // Scan from the farthest offset down so the nearest hit to rr_ptr is written last.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        idx_s     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_s = GRANT_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx_s]) begin
                pick      = idx_s;
                any_valid = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ requesters.
// Optional FIFO_ARB_STATS_EN adds saturating stall_cnt / grant_cnt outputs.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 4,
    localparam int GRANT_W    = grant_w(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_valid,
    input  logic                          fifo_full,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]             stall_cnt,
    output logic [STAT_W-1:0]             grant_cnt
`endif
);

    localparam int                   BURST_W   = grant_w(MAX_BURST);
    localparam logic [BURST_W-1:0]   LAST_BEAT = BURST_W'(MAX_BURST - 1);
    localparam logic [GRANT_W-1:0]   LAST_REQ  = GRANT_W'(NUM_REQ - 1);

    arb_state_t            state_q, state_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic [GRANT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic [GRANT_W-1:0]    pick_s;
    logic [GRANT_W-1:0]    next_ptr_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  any_s;
    logic                  load_en_s;
    logic                  grant_valid_s;
    logic                  accept_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .pick      (pick_s),
        .any_valid (any_s)
    );

    // The output register may load when empty or when the FIFO drains it this edge.
    assign load_en_s     = !valid_q || !fifo_full;
    assign grant_valid_s = req_valid[grant_q];
    assign accept_s      = (state_q == BURST) && load_en_s && grant_valid_s;
    assign next_ptr_s    = (grant_q == LAST_REQ) ? '0 : grant_q + GRANT_W'(1);

    // Select the granted requester's word.
    always_comb begin
        word_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                word_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                word_s = word_s;
            end
        end
    end

    // One-hot accept strobe toward the granted requester only.
    always_comb begin
        req_ready = '0;
        if ((state_q == BURST) && load_en_s) begin
            req_ready[grant_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic for arbitration, burst counting and the output register.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        if (accept_s) begin
            data_d      = word_s;
            valid_d     = 1'b1;
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end else if (valid_q && !fifo_full) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_d     = pick_s;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                // A full stall keeps valid high and so never ends the burst.
                if ((accept_s && (burst_cnt_q == LAST_BEAT)) || !grant_valid_s) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and output register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign fifo_data  = data_q;
    assign fifo_valid = valid_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] grant_cnt_q;

    // Saturating counters for full stalls and new grants.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            if (valid_q && fifo_full && (stall_cnt_q != STAT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if ((state_q == IDLE) && any_s && (grant_cnt_q != STAT_MAX)) begin
                grant_cnt_q <= grant_cnt_q + STAT_W'(1);
            end else begin
                grant_cnt_q <= grant_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a per-requester ordering scoreboard.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int GW = 2;

    logic          clock     = 1'b0;
    logic          rst       = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_full = 1'b0;
    logic [GW-1:0] grant_id;
    logic          busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Requester sources: requester i offers word {i, seq[i]} and advances on accept.
    int seq [N];

    // Reference model state.
    bit            m_busy;
    bit            m_ov;
    int            m_gid;
    int            m_taken;
    int            m_ptr;
    int            cyc;
    logic [DW-1:0] m_od;
    int            accepts [$];
    int            blens [$];
    logic [DW-1:0] consumed [$];

    always #5 clock = ~clock;

    fifo_wr_arbiter dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .grant_cnt  (grant_cnt)
`endif
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'((i << 24) | seq[i]);
        end
    end

    function automatic logic [DW-1:0] src_word(input int i);
        return DW'((i << 24) | seq[i]);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        if (m_busy && (!m_ov || !fifo_full)) return N'(1) << m_gid;
        return '0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_ov = 1'b0; m_gid = 0; m_taken = 0; m_ptr = 0; cyc = 0;
        m_od = '0;
        for (int i = 0; i < N; i++) seq[i] = 1;
        accepts.delete(); blens.delete(); consumed.delete();
    endtask

    // Apply one clock edge worth of arbiter rules to the model.
    task automatic model_step();
        bit acc, cons;
        int j;
        logic [N-1:0] rdy;
        rdy  = exp_ready();
        cons = m_ov && !fifo_full;
        acc  = m_busy && (rdy != '0) && req_valid[m_gid[GW-1:0]];
        if (!m_busy) begin
            if (req_valid != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    j = (m_ptr + k) % N;
                    if (req_valid[j[GW-1:0]]) m_gid = j;
                end
                m_busy = 1'b1; m_taken = 0;
            end
        end else if (acc) begin
            m_od = src_word(m_gid); m_ov = 1'b1; m_taken++; seq[m_gid]++;
            accepts.push_back(cyc);
            if (m_taken == MB) begin
                m_busy = 1'b0; m_ptr = (m_gid + 1) % N; blens.push_back(m_taken);
            end
        end else if (!req_valid[m_gid[GW-1:0]]) begin
            m_busy = 1'b0; m_ptr = (m_gid + 1) % N; blens.push_back(m_taken);
        end
        if (!acc && cons) m_ov = 1'b0;
        cyc++;
    endtask

    // Log what the FIFO takes this edge, clock once, advance the model, return to the low phase.
    task automatic cycle();
        if (fifo_valid && !fifo_full) consumed.push_back(fifo_data);
        @(posedge clock);
        #1;
        model_step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; fifo_full = 1'b0;
        @(negedge clock);
        #1;
        checks += 5;
        if (fifo_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fifo_valid); end
        if (fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", fifo_data); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        do_reset();
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_valid = {3'b000, (seq[0] <= 6)};
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                errors++; $display("FAIL single_ready cyc %0d got %b exp %b", c, req_ready, exp_ready());
            end
            cycle();
        end
        checks++;
        if (consumed.size() != 6) begin
            errors++; $display("FAIL single_count got %0d exp 6", consumed.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                w = DW'(k + 1);
                checks++;
                if (consumed[k] !== w) begin
                    errors++; $display("FAIL single_word %0d got %h exp %h", k, consumed[k], w);
                end
            end
        end
        checks++;
        if (accepts.size() != 6 || accepts[3] - accepts[0] != 3 || accepts[4] - accepts[3] != 2
            || accepts[5] - accepts[4] != 1) begin
            errors++; $display("FAIL single_spacing got %0d accepts, exp 4 back-to-back, 1 bubble, 2", accepts.size());
        end
    endtask

    task automatic test_fairness();
        int  dut_g [$];
        int  exp_g [5] = '{0, 1, 2, 3, 0};
        logic prev_busy = 1'b0;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (busy && !prev_busy) dut_g.push_back(int'(grant_id));
            prev_busy = busy;
            checks++;
            if (grant_id !== GW'(m_gid)) begin
                errors++; $display("FAIL fair_grant cyc %0d got %0d exp %0d", c, grant_id, m_gid);
            end
            cycle();
        end
        checks++;
        if (dut_g.size() < 5) begin
            errors++; $display("FAIL fair_ngrants got %0d exp 5", dut_g.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (dut_g[k] != exp_g[k]) begin
                    errors++; $display("FAIL fair_order %0d got %0d exp %0d", k, dut_g[k], exp_g[k]);
                end
            end
        end
        for (int k = 0; k < 4 && k < blens.size(); k++) begin
            checks++;
            if (blens[k] != MB) begin errors++; $display("FAIL fair_burst %0d got %0d exp 4", k, blens[k]); end
        end
    endtask

    task automatic test_backpressure();
        int stall_left = 3;
        logic [DW-1:0] w;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            req_valid = {2'b00, (seq[1] <= 4), 1'b0};
            fifo_full = (accepts.size() == 2) && (stall_left > 0);
            #1;
            if (fifo_full) begin
                checks += 3;
                if (fifo_data !== 32'h0100_0002) begin
                    errors++; $display("FAIL bp_hold_data got %h exp 01000002", fifo_data);
                end
                if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b exp 0000", req_ready); end
                if (fifo_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", fifo_valid); end
                stall_left--;
            end
            checks++;
            if (req_ready !== exp_ready()) begin
                errors++; $display("FAIL bp_ready_model cyc %0d got %b exp %b", c, req_ready, exp_ready());
            end
            cycle();
        end
        fifo_full = 1'b0;
        checks++;
        if (stall_left != 0 || consumed.size() != 4) begin
            errors++; $display("FAIL bp_count got %0d words exp 4 (stall_left %0d)", consumed.size(), stall_left);
        end else begin
            for (int k = 0; k < 4; k++) begin
                w = DW'(32'h0100_0000 + k + 1);
                checks++;
                if (consumed[k] !== w) begin errors++; $display("FAIL bp_word %0d got %h exp %h", k, consumed[k], w); end
            end
        end
    endtask

    task automatic test_early_release();
        int dut_g [$];
        logic prev_busy = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_valid = {(seq[2] > 1), (seq[2] <= 1), 1'b0, (seq[2] > 1)};
            #1;
            if (busy && !prev_busy) dut_g.push_back(int'(grant_id));
            prev_busy = busy;
            checks++;
            if (busy !== m_busy) begin errors++; $display("FAIL early_busy cyc %0d got %b exp %b", c, busy, m_busy); end
            cycle();
        end
        checks++;
        if (dut_g.size() < 2 || dut_g[0] != 2 || dut_g[1] != 3) begin
            errors++; $display("FAIL early_order got %0d grants (first %0d) exp 2 then 3", dut_g.size(),
                               (dut_g.size() > 0) ? dut_g[0] : -1);
        end
        checks++;
        if (blens.size() < 1 || blens[0] != 1) begin
            errors++; $display("FAIL early_len got %0d exp 1", (blens.size() > 0) ? blens[0] : -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dut_g [$];
        logic prev_busy = 1'b0;
        do_reset();
        req_valid = 4'b1000;
        for (int c = 0; c < 10 && accepts.size() == 0; c++) cycle();
        checks++;
        if (accepts.size() == 0) begin errors++; $display("FAIL rmb_wait got 0 accepts exp 1"); end
        fifo_full = 1'b1;
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (fifo_valid !== 1'b0) begin errors++; $display("FAIL rmb_valid got %b exp 0", fifo_valid); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmb_ready got %b exp 0000", req_ready); end
        if (grant_id !== 2'd0) begin errors++; $display("FAIL rmb_grant got %0d exp 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmb_busy got %b exp 0", busy); end
        @(negedge clock);
        model_reset();
        rst = 1'b0; fifo_full = 1'b0; req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (busy && !prev_busy) dut_g.push_back(int'(grant_id));
            prev_busy = busy;
            cycle();
        end
        checks++;
        if (dut_g.size() < 1 || dut_g[0] != 1) begin
            errors++; $display("FAIL rmb_first got %0d exp 1", (dut_g.size() > 0) ? dut_g[0] : -1);
        end
    endtask

    task automatic test_random();
        int nxt [N];
        int id;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req_valid = req_valid ^ N'($urandom() & $urandom());
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            checks += 5;
            if (req_ready !== exp_ready()) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, req_ready, exp_ready());
            end
            if (fifo_valid !== m_ov) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, fifo_valid, m_ov);
            end
            if (fifo_data !== m_od) begin
                errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, fifo_data, m_od);
            end
            if (grant_id !== GW'(m_gid)) begin
                errors++; $display("FAIL rnd_grant cyc %0d got %0d exp %0d", c, grant_id, m_gid);
            end
            if (busy !== m_busy) begin
                errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy, m_busy);
            end
            cycle();
        end
        // Per-requester words must reach the FIFO in order, each exactly once.
        for (int i = 0; i < N; i++) nxt[i] = 1;
        foreach (consumed[k]) begin
            id = int'(consumed[k][31:24]);
            checks++;
            if (id >= N || int'(consumed[k][23:0]) != nxt[id]) begin
                errors++; $display("FAIL rnd_order word %0d got %h", k, consumed[k]);
            end else begin
                nxt[id]++;
            end
        end
        checks++;
        if (consumed.size() + int'(m_ov) != accepts.size()) begin
            errors++; $display("FAIL rnd_total got %0d consumed exp %0d", consumed.size(), accepts.size() - int'(m_ov));
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        int stalls = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_valid = {3'b000, (seq[0] <= 1)};
            fifo_full = (accepts.size() >= 1) && (stalls < 5);
            if (fifo_full && fifo_valid) stalls++;
            cycle();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_valid = {1'b0, (seq[2] <= 1), (seq[1] <= 1), 1'b0};
            cycle();
        end
        checks += 2;
        if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stats_stall got %0d exp 5", stall_cnt); end
        if (grant_cnt !== 16'd3) begin errors++; $display("FAIL stats_grant got %0d exp 3", grant_cnt); end
        for (int c = 0; c < 10 && !fifo_valid; c++) begin
            req_valid = {(seq[3] <= 1), 3'b000};
            cycle();
        end
        checks++;
        if (fifo_valid !== 1'b1) begin errors++; $display("FAIL stats_wait got %b exp 1", fifo_valid); end
        fifo_full = 1'b1;
        repeat (70000) @(negedge clock);
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", stall_cnt); end
        do_reset();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_early_release();
        test_reset_mid_burst();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one FIFO write port (data_in / data_in_valid / data_in_full) between NUM_REQ requesters in the write clock domain. Grants one requester at a time for a burst of up to MAX_BURST words. Drives a registered output stage straight into the FIFO write interface and honours full backpressure without losing or duplicating words.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, word width; matches FIFO data width
MAX_BURST, 4, max words accepted per grant before re-arbitration (>=1)

Ports:
clock  input  1  write-domain clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester word-valid
req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot accept strobe; a word transfers when req_valid[i] & req_ready[i]
fifo_data  output  DATA_WIDTH  to FIFO data_in
fifo_valid  output  1  to FIFO data_in_valid
fifo_full  input  1  from FIFO data_in_full
grant_id  output  clog2(NUM_REQ)  current/last granted requester
busy  output  1  high while in BURST

Behaviour:
- Reset (async, immediate): state=IDLE, fifo_valid=0, fifo_data=0, req_ready=0, grant_id=0, rr_ptr=0, burst_cnt=0, busy=0. Any word held in the output register is discarded.
- load_en = !fifo_valid | !fifo_full. FIFO consumes the output word on any edge where fifo_valid & !fifo_full.
- IDLE: if any req_valid, pick first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. grant_id<=pick, burst_cnt<=0, state<=BURST. This costs one arbitration cycle; req_ready is 0 in IDLE.
- BURST: req_ready = onehot(grant_id) & load_en (combinational). busy=1.
- Accept (req_valid[grant_id] & req_ready): fifo_data<=word, fifo_valid<=1, burst_cnt++.
- Exit to IDLE when accepting with burst_cnt==MAX_BURST-1, or when req_valid[grant_id]==0 (no accept that cycle). On exit, rr_ptr<=(grant_id+1) mod NUM_REQ.
- No accept and fifo_valid & !fifo_full: fifo_valid<=0.
- fifo_full with fifo_valid=1: fifo_data/fifo_valid are held stable, req_ready=0, burst_cnt frozen, grant held. A full stall never ends a burst.
- Latency: req_valid seen in IDLE -> req_ready on the next cycle -> word on fifo_data one cycle after the accept. Sustained throughput inside a burst is 1 word/cycle while not full.
- Requesters other than grant_id see req_ready=0. Their req_valid changes have no effect until the next IDLE.
- Granted requester dropping valid before any accept forfeits the grant; the pointer still advances.
- Simultaneous accept and FIFO consume: the register is overwritten with the new word and fifo_valid stays 1.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output stall_cnt [15:0], a saturating count of cycles with fifo_valid & fifo_full, cleared by rst. Also adds output grant_cnt [15:0], a saturating count of IDLE->BURST transitions.
- Undefined: neither port nor counter exists. Datapath behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - localparam GRANT_W = clog2(NUM_REQ) helper function
  - localparam STAT_W = 16
- Sub-module rr_pick: combinational rotating-priority encoder. Inputs req vector and rr_ptr; outputs pick index and any-valid. Instantiated once.

Test Plan:
- Single requester: req_valid=4'b0001, words 1..6, fifo_full=0 -> words 1,2,3,4 accepted back-to-back. Then one IDLE cycle, then words 5,6. fifo_data sequence is 1..6 with no gaps besides the bubble.
- Fairness: all four req_valid held, rr_ptr=0 -> grants in order 0,1,2,3,0. Each grant gets exactly 4 words and grant_id matches the sequence.
- Backpressure: fifo_full asserted for 3 cycles after the 2nd word of a burst -> fifo_data is held at word 2 and req_ready=0 for 3 cycles. Then words 3,4 follow and there is no drop or duplicate.
- Early release: requester 2 drops valid after 1 word -> state returns to IDLE, rr_ptr=3, and requester 3 is granted next ahead of 0.
- Reset mid-burst: assert rst while fifo_valid=1 and fifo_full=1 -> fifo_valid=0, req_ready=0, grant_id=0 immediately (asynchronously). After release, the first grant goes to the lowest valid index.
- FIFO_ARB_STATS_EN build: 5 full-stall cycles plus 3 grants -> stall_cnt=5, grant_cnt=3. Forcing 70000 stall cycles -> stall_cnt saturates at 16'hFFFF.
